// File: rtl/game_link_pkg.sv
// Shared constants, state types and frame helpers for the board-to-board game link.
package game_link_pkg;

  localparam logic [7:0]  LINK_SYNC_BYTE = 8'hD5;
  localparam int unsigned FLAG_STARTED   = 0;
  localparam int unsigned FLAG_FINISHED  = 1;
  localparam int unsigned SEQ_LSB        = 4;
  localparam int unsigned FRAME_BYTES    = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_FLAGS,
    TX_HI,
    TX_LO,
    TX_CHK
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_FLAGS,
    RX_HI,
    RX_LO,
    RX_CHK
  } rx_state_t;

  function automatic logic [7:0] link_flags(logic [3:0] seq, logic finished, logic started);
    logic [7:0] f;
    f                 = '0;
    f[FLAG_STARTED]   = started;
    f[FLAG_FINISHED]  = finished;
    f[SEQ_LSB +: 4]   = seq;
    return f;
  endfunction

endpackage

// File: rtl/game_link_rx.sv
// Enemy frame parser: hunts for sync, checks checksum and score range, counts rejects.
module game_link_rx
  import game_link_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   frame_ok,
  output logic                   rx_started,
  output logic                   rx_finished,
  output logic [SCORE_WIDTH-1:0] rx_score,
  output logic [7:0]             frame_err_cnt
);

  rx_state_t   state_q, state_d;
  logic [7:0]  acc_q, acc_d;      // running xor of FLAGS, HI and LO
  logic        st_q, st_d;
  logic        fin_q, fin_d;
  logic [15:0] score_q, score_d;
  logic        frame_end, chk_ok, range_ok;

  assign frame_end = (state_q == RX_CHK) && rx_valid;
  assign chk_ok    = (rx_data == acc_q);
  assign range_ok  = ((32'(score_q) >> SCORE_WIDTH) == 32'd0);
  assign frame_ok  = frame_end && chk_ok && range_ok;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    st_d    = st_q;
    fin_d   = fin_q;
    score_d = score_q;
    if (rx_valid) begin
      unique case (state_q)
        RX_HUNT: if (rx_data == LINK_SYNC_BYTE) state_d = RX_FLAGS;
        RX_FLAGS: begin
          acc_d   = rx_data;
          st_d    = rx_data[FLAG_STARTED];
          fin_d   = rx_data[FLAG_FINISHED];
          state_d = RX_HI;
        end
        RX_HI: begin
          acc_d          = acc_q ^ rx_data;
          score_d[15:8]  = rx_data;
          state_d        = RX_LO;
        end
        RX_LO: begin
          acc_d         = acc_q ^ rx_data;
          score_d[7:0]  = rx_data;
          state_d       = RX_CHK;
        end
        RX_CHK:  state_d = RX_HUNT;
        default: state_d = RX_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_HUNT;
      acc_q   <= '0;
      st_q    <= 1'b0;
      fin_q   <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      st_q    <= st_d;
      fin_q   <= fin_d;
      score_q <= score_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_started    <= 1'b0;
      rx_finished   <= 1'b0;
      rx_score      <= '0;
      frame_err_cnt <= '0;
    end else if (frame_ok) begin
      rx_started  <= st_q;
      rx_finished <= fin_q;
      rx_score    <= score_q[SCORE_WIDTH-1:0];
    end else if (frame_end && frame_err_cnt != 8'hFF) begin
      frame_err_cnt <= frame_err_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/game_link_ctl.sv
// Game link controller: periodic/on-change framed status TX plus enemy frame RX.
// Optional link watchdog enabled by defining LINK_WATCHDOG_EN.
module game_link_ctl
  import game_link_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH      = 7,
  parameter int unsigned TX_PERIOD_CYCLES = 400_000,
  parameter int unsigned TIMEOUT_FRAMES   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   my_started,
  input  logic                   my_finished,
  input  logic [SCORE_WIDTH-1:0] my_score,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   enemy_started,
  output logic                   enemy_finished,
  output logic [SCORE_WIDTH-1:0] enemy_score,
  output logic                   link_up,
  output logic [7:0]             frame_err_cnt
);

  localparam int unsigned TimerW = (TX_PERIOD_CYCLES > 1) ? $clog2(TX_PERIOD_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerReload = TimerW'(TX_PERIOD_CYCLES - 1);

  tx_state_t               state_q, state_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [3:0]              seq_q, seq_d;
  logic                    snap_st_q, snap_st_d;
  logic                    snap_fin_q, snap_fin_d;
  logic [SCORE_WIDTH-1:0]  snap_score_q, snap_score_d;
  logic                    changed;
  logic [15:0]             score16;
  logic [7:0]              flags;

  assign changed = {my_started, my_finished, my_score} != {snap_st_q, snap_fin_q, snap_score_q};
  assign score16 = 16'(snap_score_q);
  assign flags   = link_flags(seq_q, snap_fin_q, snap_st_q);

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    snap_st_d    = snap_st_q;
    snap_fin_d   = snap_fin_q;
    snap_score_d = snap_score_q;
    // Timer parks at zero, so an expiry during a frame is held until TX_IDLE services it.
    timer_d      = (timer_q != '0) ? timer_q - TimerW'(1) : timer_q;
    unique case (state_q)
      TX_IDLE: begin
        if (timer_q == '0 || changed) begin
          state_d      = TX_SYNC;
          snap_st_d    = my_started;
          snap_fin_d   = my_finished;
          snap_score_d = my_score;
          timer_d      = TimerReload;
          seq_d        = seq_q + 4'd1;
        end
      end
      TX_SYNC:  if (tx_ready) state_d = TX_FLAGS;
      TX_FLAGS: if (tx_ready) state_d = TX_HI;
      TX_HI:    if (tx_ready) state_d = TX_LO;
      TX_LO:    if (tx_ready) state_d = TX_CHK;
      TX_CHK:   if (tx_ready) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_data  = '0;
    tx_valid = (state_q != TX_IDLE);
    unique case (state_q)
      TX_SYNC:  tx_data = LINK_SYNC_BYTE;
      TX_FLAGS: tx_data = flags;
      TX_HI:    tx_data = score16[15:8];
      TX_LO:    tx_data = score16[7:0];
      TX_CHK:   tx_data = flags ^ score16[15:8] ^ score16[7:0];
      default:  tx_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      timer_q      <= '0;
      seq_q        <= '0;
      snap_st_q    <= 1'b0;
      snap_fin_q   <= 1'b0;
      snap_score_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      seq_q        <= seq_d;
      snap_st_q    <= snap_st_d;
      snap_fin_q   <= snap_fin_d;
      snap_score_q <= snap_score_d;
    end
  end

  logic frame_ok, rx_started, rx_finished, seen_q, alive;

  game_link_rx #(
    .SCORE_WIDTH (SCORE_WIDTH)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_ok      (frame_ok),
    .rx_started    (rx_started),
    .rx_finished   (rx_finished),
    .rx_score      (enemy_score),
    .frame_err_cnt (frame_err_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 1'b0;
    end else if (frame_ok) begin
      seen_q <= 1'b1;
    end
  end

`ifdef LINK_WATCHDOG_EN
  localparam int unsigned WdLimit = TIMEOUT_FRAMES * TX_PERIOD_CYCLES;
  localparam int unsigned WdW     = $clog2(WdLimit + 1);

  logic [WdW-1:0] wd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (frame_ok) begin
      wd_q <= '0;
    end else if (wd_q != WdW'(WdLimit)) begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  assign alive = (wd_q != WdW'(WdLimit));
`else
  assign alive = 1'b1;
`endif

  // Flags are masked while the watchdog has expired; the score is deliberately held.
  assign link_up        = seen_q & alive;
  assign enemy_started  = rx_started & alive;
  assign enemy_finished = rx_finished & alive;

endmodule

// File: tb/tb_game_link_ctl.sv
// Self-checking bench for game_link_ctl: loopback, directed and random enemy frames, TX stalls.
`timescale 1ns/1ps
module tb_game_link_ctl;
  import game_link_pkg::*;

  localparam int unsigned SW  = 7;
  localparam int unsigned PER = 100;
  localparam int unsigned TOF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          my_started = 1'b0, my_finished = 1'b0;
  logic [SW-1:0] my_score = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          enemy_started, enemy_finished, link_up;
  logic [SW-1:0] enemy_score;
  logic [7:0]    frame_err_cnt;
  logic          loop = 1'b0;
  logic [7:0]    inj_data = '0;
  logic          inj_valid = 1'b0;

  assign rx_data  = loop ? tx_data : inj_data;
  assign rx_valid = loop ? (tx_valid & tx_ready) : inj_valid;

  game_link_ctl #(
    .SCORE_WIDTH      (SW),
    .TX_PERIOD_CYCLES (PER),
    .TIMEOUT_FRAMES   (TOF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .my_started     (my_started),
    .my_finished    (my_finished),
    .my_score       (my_score),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .enemy_started  (enemy_started),
    .enemy_finished (enemy_finished),
    .enemy_score    (enemy_score),
    .link_up        (link_up),
    .frame_err_cnt  (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted TX byte with the cycle it was on the bus.
  logic [7:0] txq[$];
  int         tsq[$];
  always @(negedge clk) begin
    if (rst) begin
      txq.delete();
      tsq.delete();
    end else if (tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      tsq.push_back(cyc);
    end
  end

  int tests = 0, fails = 0;

  // Reference model of what the enemy side should report.
  logic m_st = 1'b0, m_fin = 1'b0, m_seen = 1'b0;
  int   m_score = 0, m_err = 0, m_last = 0, n_frames = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags_of(int n, logic fin, logic st);
    return {4'(n % 16), 2'b00, fin, st};
  endfunction

  function automatic logic [39:0] mk_frame(logic [7:0] fl, logic [15:0] sc);
    return {8'hD5, fl, sc, fl ^ sc[15:8] ^ sc[7:0]};
  endfunction

  function automatic logic exp_alive();
`ifdef LINK_WATCHDOG_EN
    return (cyc - m_last) < int'(TOF * PER);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_rx(logic [39:0] fr);
    logic [7:0] fl, hi, lo, ck;
    {fl, hi, lo, ck} = fr[31:0];
    if ((fl ^ hi ^ lo) == ck && int'({hi, lo}) < (1 << SW)) begin
      m_st = fl[0]; m_fin = fl[1]; m_score = int'({hi, lo}); m_seen = 1'b1; m_last = cyc;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic check_enemy(string tag);
    logic a;
    a = exp_alive();
    chk({tag, "_link"}, link_up, m_seen & a);
    chk({tag, "_st"}, enemy_started, m_st & a);
    chk({tag, "_fin"}, enemy_finished, m_fin & a);
    chk({tag, "_score"}, enemy_score, m_score);
    chk({tag, "_err"}, frame_err_cnt, m_err);
  endtask

  task automatic inject_byte(logic [7:0] b);
    inj_data = b; inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
  endtask

  task automatic inject(logic [39:0] fr, bit gaps);
    for (int i = 4; i >= 0; i--) begin
      inject_byte(fr[i*8 +: 8]);
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_q(int n, string tag, output bit ok);
    int k;
    k = 0;
    while (txq.size() < n && k < 1000) begin @(posedge clk); #1; k++; end
    ok = (txq.size() >= n);
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_idle(string tag);
    int k;
    k = 0;
    while (tx_valid && k < 50) begin @(posedge clk); #1; k++; end
    chk(tag, tx_valid, 1'b0);
  endtask

  task automatic pop_frame(output logic [39:0] fr, output int ts_sync, output int ts_chk);
    fr = '0;
    ts_sync = tsq[0];
    ts_chk = 0;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      fr = {fr[31:0], txq.pop_front()};
      ts_chk = tsq.pop_front();
    end
    n_frames++;
    chk("fr_sync", fr[39:32], 8'hD5);
    chk("fr_seq", fr[31:28], 32'(n_frames % 16));
    chk("fr_rsv", fr[27:26], 2'b00);
    chk("fr_chk", fr[7:0], fr[31:24] ^ fr[23:16] ^ fr[15:8]);
    chk("fr_range", 32'(int'(fr[23:8]) < (1 << SW)), 1);
  endtask

  task automatic drain();
    logic [39:0] fr;
    int a, b;
    while (txq.size() >= FRAME_BYTES) pop_frame(fr, a, b);
  endtask

  logic [39:0] fa, fb, fr;
  logic [7:0]  fl, nb;
  logic [15:0] sc;
  int          ka, kb, ta, tb, kind, k;
  bit          ok;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    check_enemy("rst");

    // Loopback: first frame starts on the first cycle after release.
    my_score = 7'd37; my_started = 1'b1; tx_ready = 1'b1; loop = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_sync_valid", tx_valid, 1'b1);
    chk("first_sync_data", tx_data, 8'hD5);
    k = 0;
    while (!(txq.size() == 4 && tx_valid && tx_ready) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("lb_fifth_byte", txq.size(), 4);
    chk("lb_pre_link", link_up, 1'b0);
    @(posedge clk); #1;
    model_rx(mk_frame(flags_of(1, 1'b0, 1'b1), 16'd37));
    check_enemy("lb");
    loop = 1'b0;

    // Periodic frame spacing with unchanged inputs.
    wait_q(10, "wait_period", ok);
    if (ok) begin
      pop_frame(fa, ka, kb);
      pop_frame(fb, ta, tb);
      chk("frame1", fa[31:0], mk_frame(flags_of(1, 1'b0, 1'b1), 16'd37));
      chk("frame2", fb[31:0], mk_frame(flags_of(2, 1'b0, 1'b1), 16'd37));
      chk("period_gap", ta - ka, PER);
    end

    // Directed enemy frames.
    fr = mk_frame(8'h00, 16'd0);  inject(fr, 1'b0); model_rx(fr); check_enemy("zero");
    fr = 40'hD5_01_00_25_FF;      inject(fr, 1'b0); model_rx(fr); check_enemy("bad_chk");
    fr = 40'hD5_01_00_25_24;      inject(fr, 1'b0); model_rx(fr); check_enemy("good37");
    fr = 40'hD5_01_01_2C_2C;      inject(fr, 1'b0); model_rx(fr); check_enemy("score300");
    fr = mk_frame(8'hD5, 16'd100); inject(fr, 1'b1); model_rx(fr); check_enemy("flags_d5");

    // Random enemy frames: valid, bad checksum, out of range, leading noise.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      fl = 8'($urandom);
      sc = 16'($urandom_range(0, (1 << SW) - 1));
      fr = mk_frame(fl, sc);
      if (kind == 1) fr[7:0] = fr[7:0] ^ 8'($urandom_range(1, 255));
      if (kind == 2) begin
        sc = 16'($urandom_range(1 << SW, 65535));
        fr = mk_frame(fl, sc);
      end
      if (kind == 3) begin
        repeat ($urandom_range(1, 3)) begin
          nb = 8'($urandom);
          if (nb == 8'hD5) nb = 8'h00;
          inject_byte(nb);
        end
      end
      inject(fr, 1'b1); model_rx(fr); check_enemy("rand");
    end

    // Link silence boundary: watchdog build drops the link exactly TOF*PER cycles later.
    fr = mk_frame(8'h03, 16'd88); inject(fr, 1'b0); model_rx(fr);
    repeat (TOF * PER - 1) @(posedge clk);
    #1; check_enemy("quiet_before");
    @(posedge clk); #1; check_enemy("quiet_at");
    fr = mk_frame(8'h01, 16'd12); inject(fr, 1'b0); model_rx(fr); check_enemy("quiet_after");

    // TX stall in TX_HI with a score change during TX_FLAGS.
    wait_idle("idle_before_stall");
    drain();
    tx_ready = 1'b0; my_score = 7'd5;
    @(posedge clk); #1;
    chk("stall_sync_valid", tx_valid, 1'b1);
    chk("stall_sync_data", tx_data, 8'hD5);
    tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
    my_score = 7'd6;
    chk("stall_flags", tx_data, flags_of(n_frames + 1, 1'b0, 1'b1));
    tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("stall_hi_valid", tx_valid, 1'b1);
      chk("stall_hi_data", tx_data, 8'h00);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_q(10, "wait_stall_frames", ok);
    if (ok) begin
      pop_frame(fa, ka, kb);
      pop_frame(fb, ta, tb);
      chk("stall_frame_a", fa[31:0], mk_frame(flags_of(n_frames - 1, 1'b0, 1'b1), 16'd5));
      chk("stall_frame_b", fb[31:0], mk_frame(flags_of(n_frames, 1'b0, 1'b1), 16'd6));
      chk("change_gap", ta - kb, 2);
    end

    // Error counter saturation.
    while (m_err < 258) begin
      fr = 40'hD5_01_00_25_FF; inject(fr, 1'b0); model_rx(fr);
      if (m_err == 255) m_err = 258;
    end
    m_err = 255;
    fr = 40'hD5_01_00_25_FF; inject(fr, 1'b0); model_rx(fr); check_enemy("sat");

    // Reset in the middle of a TX frame and an RX frame.
    wait_idle("idle_before_rst");
    tx_ready = 1'b0; my_score = 7'd9;
    inject_byte(8'hD5);
    inject_byte(8'h01);
    chk("pre_rst_valid", tx_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    m_st = 1'b0; m_fin = 1'b0; m_seen = 1'b0; m_score = 0; m_err = 0; m_last = 0; n_frames = 0;
    chk("rst_mid_valid", tx_valid, 1'b0);
    chk("rst_mid_data", tx_data, 8'h00);
    check_enemy("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    inject_byte(8'h00);
    chk("post_rst_valid", tx_valid, 1'b1);
    chk("post_rst_data", tx_data, 8'hD5);
    inject_byte(8'h25);
    inject_byte(8'h24);
    check_enemy("post_rst_partial");
    tx_ready = 1'b1;
    fr = mk_frame(8'($urandom), 16'($urandom_range(0, (1 << SW) - 1)));
    inject(fr, 1'b1); model_rx(fr); check_enemy("post_rst_frame");
    wait_q(5, "wait_post_rst", ok);
    if (ok) begin
      pop_frame(fa, ka, kb);
      chk("post_rst_tx_frame", fa[31:0], mk_frame(flags_of(1, 1'b0, 1'b1), 16'd9));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
